matrix_scan_ctrl: RTL
=====================

# matrix_scan_ctrl

Scan controller for the 16x16 LED matrix display. It walks the frame buffer one row at a time and shifts each row's 16 column bits into the column shift register (CSDI/CCLK). It advances the one-hot row shift register (RSDI/RCLK), latches both registers (LE) and enables the outputs (OEB) for a fixed dwell time per row. It sits between the game-state frame buffer and the matrix driver pins, and replaces ad-hoc scan logic inside the game core.

## Interface
Parameters:
- SCREENTIMERWIDTH, default 10: dwell counter width; each row is displayed for 2^SCREENTIMERWIDTH clk cycles.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  scan enable; level-sensitive.
- row_addr  out  4  frame-buffer row being fetched.
- row_data  in  16  frame-buffer row contents; valid the cycle after row_addr changes; bit 15 = leftmost column.
- frame_done  out  1  one-cycle pulse at the end of row 15's dwell.
- CSDI  out  1  column serial data.
- CCLK  out  1  column shift clock; data shifts on rising edge.
- RSDI  out  1  row serial data.
- RCLK  out  1  row shift clock.
- LE  out  1  latch enable for row and column registers, active high.
- OEB  out  1  output enable bar; 1 = matrix blanked.

## Operation
- All outputs are registered.
- Reset values: state IDLE, row counter 0, row_addr 0, frame_done 0, CSDI/CCLK/RSDI/RCLK/LE all 0, OEB 1.
- row_addr always equals the internal row counter.
- The row counter is a 4-bit counter. It wraps 15→0 without saturating.
- IDLE: OEB=1. If enable=1, go to FETCH.
- FETCH (1 cycle): at the end of the cycle, capture row_data into the 16-bit column shift register.
- SHIFT (32 cycles): the bit index i runs 0..15.
  - Cycle 2i: CSDI = colsr[15], CCLK=0.
  - Cycle 2i+1: CSDI held, CCLK=1. At the end of the cycle, colsr shifts left by 1.
  - Bit 15 is transmitted first.
- ROWCLK (2 cycles): RSDI = 1 iff the row counter is 0, otherwise 0. RCLK=0 in the first cycle and 1 in the second.
- LATCH (1 cycle): LE=1. Every other strobe is 0.
- DISPLAY (2^SCREENTIMERWIDTH cycles): OEB=0. The dwell counter starts from 0 and ends at all-ones.
- End of DISPLAY:
  - The row counter increments.
  - If the row counter was 15, frame_done=1 for the next cycle.
  - If enable=1, go to FETCH. Otherwise go to IDLE and force the row counter to 0.
- OEB=1 in every state except DISPLAY. The matrix is blanked while the shift registers change.
- Outside SHIFT, CSDI=0 and CCLK=0. Outside ROWCLK, RSDI=0 and RCLK=0.
- enable is sampled only in IDLE and in the last DISPLAY cycle. Deasserting it mid-row completes that row (including its dwell) before going idle.
- An asynchronous reset in any state returns immediately to the reset values. No partial strobe or pulse survives it.

## Timing
- Row period: 1 + 32 + 2 + 1 + 2^SCREENTIMERWIDTH = 36 + 2^SCREENTIMERWIDTH cycles.
- Frame period: 16 × row period. With enable held high, frame_done pulses exactly once per frame period.
- Pulse widths:
  - CCLK high: 1 cycle per bit.
  - RCLK high: 1 cycle per row.
  - LE high: 1 cycle per row.
  - OEB low: 2^SCREENTIMERWIDTH consecutive cycles per row.
- From enable rising in IDLE: FETCH starts the next cycle, and the first CCLK rising edge comes 3 cycles after the enable-sampling edge.
- Data setup: CSDI is stable one full cycle before each CCLK rise. RSDI is stable one full cycle before each RCLK rise.
- frame_done asserts in the first cycle after row 15's last DISPLAY cycle, i.e. concurrent with the next FETCH of row 0, or with IDLE.

## Test plan
- Reset, then release with enable=0: OEB=1, all strobes 0, row_addr=0, no activity for 1000 cycles.
- SCREENTIMERWIDTH=2, enable=1, row_data=16'hA5C3 for row 0:
  - Exactly 16 CCLK rises.
  - CSDI sampled at the rises gives 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
  - Then one RCLK rise with RSDI=1, one LE pulse, then OEB low for 4 cycles.
  - Row period is 40 cycles.
- Full frame with row_data = {12'h0, row_addr}, SCREENTIMERWIDTH=2:
  - row_addr steps 0..15 every 40 cycles.
  - RSDI=1 only at row 0's RCLK rise.
  - frame_done pulses once, at cycle 640, then row_addr wraps to 0.
- Drop enable during row 7's SHIFT:
  - Row 7 completes, including its OEB-low dwell.
  - The block then goes to IDLE with row_addr=0 and no frame_done.
  - Re-enabling restarts at row 0.
- Assert reset_n=0 mid-LATCH and mid-DISPLAY: LE and OEB return to 0 and 1 respectively in the same cycle (asynchronously). After release, scanning resumes from row 0.
- Check the invariant on every cycle in all runs: OEB=0 never coincides with CCLK, RCLK or LE being high.

Source files
------------

// File: rtl/matrix_scan_ctrl_if.sv
// Frame-buffer fetch and LED matrix driver pins of the scan controller.
// master = scan controller, slave = frame buffer / pin consumer.
interface matrix_scan_ctrl_if;
  logic        enable;
  logic [3:0]  row_addr;
  logic [15:0] row_data;
  logic        frame_done;
  logic        CSDI;
  logic        CCLK;
  logic        RSDI;
  logic        RCLK;
  logic        LE;
  logic        OEB;

  modport master (
    input  enable,
    input  row_data,
    output row_addr,
    output frame_done,
    output CSDI,
    output CCLK,
    output RSDI,
    output RCLK,
    output LE,
    output OEB
  );

  modport slave (
    output enable,
    output row_data,
    input  row_addr,
    input  frame_done,
    input  CSDI,
    input  CCLK,
    input  RSDI,
    input  RCLK,
    input  LE,
    input  OEB
  );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// 16x16 LED matrix scan controller: fetches each frame-buffer row, shifts it
// into the column register, clocks the one-hot row register, latches, dwells.
module matrix_scan_ctrl #(
  parameter int unsigned SCREENTIMERWIDTH = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  matrix_scan_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_ROWCLK,
    S_LATCH,
    S_DISPLAY
  } state_t;

  state_t                      state_q, state_d;
  logic [4:0]                  phase_q, phase_d;
  logic [SCREENTIMERWIDTH-1:0] dwell_q, dwell_d;
  logic [3:0]                  row_q, row_d;
  logic [15:0]                 colsr_q, colsr_d;
  logic                        last_dwell;

  logic csdi_d, cclk_d, rsdi_d, rclk_d, le_d, oeb_d, fd_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      dwell_q <= '0;
      row_q   <= '0;
      colsr_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      row_q   <= row_d;
      colsr_q <= colsr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    dwell_d    = dwell_q;
    row_d      = row_q;
    colsr_d    = colsr_q;
    last_dwell = 1'b0;
    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        if (bus.enable) state_d = S_FETCH;
      end
      S_FETCH: begin
        colsr_d = bus.row_data;
        phase_d = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // even phase presents the bit, odd phase clocks it, then shift
        phase_d = phase_q + 5'd1;
        if (phase_q[0]) colsr_d = {colsr_q[14:0], 1'b0};
        if (phase_q == 5'd31) begin
          phase_d = '0;
          state_d = S_ROWCLK;
        end
      end
      S_ROWCLK: begin
        phase_d = phase_q + 5'd1;
        if (phase_q[0]) begin
          phase_d = '0;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        dwell_d = '0;
        state_d = S_DISPLAY;
      end
      S_DISPLAY: begin
        dwell_d = dwell_q + 1'b1;
        if (dwell_q == '1) begin
          last_dwell = 1'b1;
          if (bus.enable) begin
            row_d   = row_q + 4'd1;
            state_d = S_FETCH;
          end else begin
            row_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin values are a registered image of the current state, so every pin
  // trails the state by one cycle; this keeps all outputs glitch-free flops.
  always_comb begin
    csdi_d = (state_q == S_SHIFT) && colsr_q[15];
    cclk_d = (state_q == S_SHIFT) && phase_q[0];
    rsdi_d = (state_q == S_ROWCLK) && (row_q == 4'd0);
    rclk_d = (state_q == S_ROWCLK) && phase_q[0];
    le_d   = (state_q == S_LATCH);
    oeb_d  = (state_q != S_DISPLAY);
    fd_d   = last_dwell && (row_q == 4'd15);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.CSDI       <= 1'b0;
      bus.CCLK       <= 1'b0;
      bus.RSDI       <= 1'b0;
      bus.RCLK       <= 1'b0;
      bus.LE         <= 1'b0;
      bus.OEB        <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.CSDI       <= csdi_d;
      bus.CCLK       <= cclk_d;
      bus.RSDI       <= rsdi_d;
      bus.RCLK       <= rclk_d;
      bus.LE         <= le_d;
      bus.OEB        <= oeb_d;
      bus.frame_done <= fd_d;
    end
  end

  assign bus.row_addr = row_q;

endmodule
